// File: rtl/io_cfg_pkg.sv
// Shared definitions for the I/O-tile configuration-chain programmer.
package io_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } ccff_state_e;

    localparam int unsigned DEF_CHAIN_LEN = 64;
    localparam int unsigned DEF_WORD_W    = 8;

endpackage

// File: rtl/io_ccff_serializer.sv
// Word shift register with a bits-left counter; bit 0 is presented first.
module io_ccff_serializer #(
    parameter  int unsigned WORD_W = 8,
    localparam int unsigned BL_W   = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic [BL_W-1:0]   load_bits,
    input  logic              shift,
    output logic              head_bit,
    output logic              last_c
);

    logic [WORD_W-1:0] sreg;
    logic [BL_W-1:0]   bits_left;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg      <= '0;
            bits_left <= '0;
        end else if (load) begin
            sreg      <= load_data;
            bits_left <= load_bits;
        end else if (shift) begin
            sreg      <= sreg >> 1;
            bits_left <= bits_left - BL_W'(1);
        end
    end

    assign head_bit = sreg[0];
    assign last_c   = (bits_left == BL_W'(1));

endmodule

// File: rtl/io_ccff_chain_loader.sv
// Configuration-chain programmer: serialises bitstream words LSB-first into ccff_head
// and optionally compares the previous chain contents emerging on ccff_tail.
module io_ccff_chain_loader
    import io_cfg_pkg::*;
#(
    parameter  int unsigned CHAIN_LEN = DEF_CHAIN_LEN,
    parameter  int unsigned WORD_W    = DEF_WORD_W,
    localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              verify,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done,
    output logic              mismatch,
    output logic [CNT_W-1:0]  bit_count
);

    localparam int unsigned BL_W = $clog2(WORD_W + 1);

    ccff_state_e      state_q, state_d;
    logic             verify_q, verify_d;
    logic             head_d, shift_en_d, mismatch_d;
    logic [CNT_W-1:0] count_d;
    logic             ser_load, ser_shift, ser_bit, ser_last_c;
    logic [31:0]      rem_bits;
    logic [BL_W-1:0]  load_bits;

    io_ccff_serializer #(.WORD_W(WORD_W)) u_ser (
        .clk       (prog_clk),
        .rst       (pReset),
        .load      (ser_load),
        .load_data (word_data),
        .load_bits (load_bits),
        .shift     (ser_shift),
        .head_bit  (ser_bit),
        .last_c    (ser_last_c)
    );

    // Last word of a pass is trimmed so only CHAIN_LEN bits are ever shifted.
    always_comb begin
        rem_bits  = CHAIN_LEN - 32'(bit_count);
        load_bits = (rem_bits > WORD_W) ? BL_W'(WORD_W) : BL_W'(rem_bits);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        verify_d   = verify_q;
        head_d     = ccff_head;
        shift_en_d = 1'b0;
        count_d    = bit_count;
        mismatch_d = mismatch;
        ser_load   = 1'b0;
        ser_shift  = 1'b0;

        // Tail shows bit k of the previous pass while bit k of this pass enters.
        if (ccff_shift_en && verify_q && (ccff_tail != ccff_head)) begin
            mismatch_d = 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_FETCH;
                    verify_d   = verify;
                    count_d    = '0;
                    mismatch_d = 1'b0;
                end
            end
            ST_FETCH: begin
                if (word_valid && word_ready) begin
                    ser_load = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                head_d     = ser_bit;
                shift_en_d = 1'b1;
                ser_shift  = 1'b1;
                if (bit_count < CNT_W'(CHAIN_LEN)) begin
                    count_d = bit_count + CNT_W'(1);
                end
                if (ser_last_c) begin
                    state_d = (bit_count == CNT_W'(CHAIN_LEN - 1)) ? ST_DONE : ST_FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q       <= ST_IDLE;
            verify_q      <= 1'b0;
            word_ready    <= 1'b0;
            ccff_head     <= 1'b0;
            ccff_shift_en <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            mismatch      <= 1'b0;
            bit_count     <= '0;
        end else begin
            state_q       <= state_d;
            verify_q      <= verify_d;
            word_ready    <= (state_d == ST_FETCH);
            ccff_head     <= head_d;
            ccff_shift_en <= shift_en_d;
            busy          <= (state_d == ST_FETCH) || (state_d == ST_SHIFT);
            done          <= (state_d == ST_DONE);
            mismatch      <= mismatch_d;
            bit_count     <= count_d;
        end
    end

endmodule

// File: tb/tb_io_ccff_chain_loader.sv
// Bench for io_ccff_chain_loader: three chain geometries, each DUT feeding a
// behavioural chain model; results compared against expectations built from the word stream.
module tb_io_ccff_chain_loader;

    localparam int unsigned N_INST  = 3;
    localparam int unsigned MAX_LEN = 64;
    localparam int unsigned WW      = 8;

    logic clk;
    logic p_reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [N_INST-1:0] start_v, verify_v, valid_v, tail_v;
    logic [WW-1:0]     data_v [N_INST];
    logic [N_INST-1:0] ready_o, head_o, sen_o, busy_o, done_o, mm_o;
    logic [6:0]        bc_o [N_INST];
    logic [6:0]        bc_w0;
    logic [3:0]        bc_w1;
    logic [0:0]        bc_w2;

    assign bc_o[0] = bc_w0;
    assign bc_o[1] = 7'(bc_w1);
    assign bc_o[2] = 7'(bc_w2);

    io_ccff_chain_loader #(.CHAIN_LEN(64), .WORD_W(8)) u_dut0 (
        .prog_clk(clk), .pReset(p_reset), .start(start_v[0]), .verify(verify_v[0]),
        .word_valid(valid_v[0]), .word_data(data_v[0]), .word_ready(ready_o[0]),
        .ccff_head(head_o[0]), .ccff_tail(tail_v[0]), .ccff_shift_en(sen_o[0]),
        .busy(busy_o[0]), .done(done_o[0]), .mismatch(mm_o[0]), .bit_count(bc_w0));

    io_ccff_chain_loader #(.CHAIN_LEN(10), .WORD_W(8)) u_dut1 (
        .prog_clk(clk), .pReset(p_reset), .start(start_v[1]), .verify(verify_v[1]),
        .word_valid(valid_v[1]), .word_data(data_v[1]), .word_ready(ready_o[1]),
        .ccff_head(head_o[1]), .ccff_tail(tail_v[1]), .ccff_shift_en(sen_o[1]),
        .busy(busy_o[1]), .done(done_o[1]), .mismatch(mm_o[1]), .bit_count(bc_w1));

    io_ccff_chain_loader #(.CHAIN_LEN(1), .WORD_W(8)) u_dut2 (
        .prog_clk(clk), .pReset(p_reset), .start(start_v[2]), .verify(verify_v[2]),
        .word_valid(valid_v[2]), .word_data(data_v[2]), .word_ready(ready_o[2]),
        .ccff_head(head_o[2]), .ccff_tail(tail_v[2]), .ccff_shift_en(sen_o[2]),
        .busy(busy_o[2]), .done(done_o[2]), .mismatch(mm_o[2]), .bit_count(bc_w2));

    function automatic int unsigned len_of(input int i);
        return (i == 0) ? 64 : ((i == 1) ? 10 : 1);
    endfunction

    // Chain model: a CHAIN_LEN shift register, head enters at the top, tail is bit 0.
    logic [MAX_LEN-1:0] chain_m [N_INST];
    int                 shift_cnt [N_INST];
    int                 accept_cnt [N_INST];

    always @(posedge clk) begin
        for (int i = 0; i < int'(N_INST); i++) begin
            if (sen_o[i]) begin
                chain_m[i]   <= (chain_m[i] >> 1) | (MAX_LEN'(head_o[i]) << (len_of(i) - 1));
                shift_cnt[i] <= shift_cnt[i] + 1;
            end
            if (valid_v[i] && ready_o[i]) accept_cnt[i] <= accept_cnt[i] + 1;
        end
    end

    assign tail_v = {chain_m[2][0], chain_m[1][0], chain_m[0][0]};

    int   n_vec = 0;
    int   n_err = 0;
    int   k_cyc, first_sen, feed_w;
    logic first_head;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int inst);
        tick();
        k_cyc++;
        if (first_sen < 0 && sen_o[inst]) begin
            first_sen  = k_cyc;
            first_head = head_o[inst];
        end
    endtask

    // One full programming pass with expectations derived from the word stream.
    task automatic run_pass(input int inst, input logic [WW-1:0] words [8], input bit ver,
                            input int stall_after, input int stall_len, input string tag);
        int unsigned        len;
        int                 nw, w, stall_left, stall_sen, budget, sc0, ac0;
        bit                 hs;
        logic [MAX_LEN-1:0] old, exp_chain;
        logic               exp_mm;
        len       = len_of(inst);
        nw        = int'((len + WW - 1) / WW);
        old       = chain_m[inst];
        exp_chain = '0;
        exp_mm    = 1'b0;
        for (int k = 0; k < int'(len); k++) begin
            exp_chain[k] = words[k / WW][k % WW];
            if (ver && (exp_chain[k] != old[k])) exp_mm = 1'b1;
        end
        sc0 = shift_cnt[inst];
        ac0 = accept_cnt[inst];

        start_v[inst]  = 1'b1;
        verify_v[inst] = ver;
        valid_v[inst]  = 1'b1;
        data_v[inst]   = words[0];
        first_sen      = -1;
        tick();
        k_cyc          = 0;
        start_v[inst]  = 1'b0;
        check({tag, "_busy_after_start"}, busy_o[inst], 1);
        check({tag, "_ready_after_start"}, ready_o[inst], 1);

        w = 0; stall_left = stall_len; stall_sen = 0; budget = 4000;
        while (w < nw && budget > 0) begin
            if (w == stall_after && stall_left > 0) begin
                valid_v[inst] = 1'b0;
                if (ready_o[inst]) begin
                    if (stall_left < stall_len) stall_sen += int'(sen_o[inst]);
                    stall_left--;
                end
            end else begin
                valid_v[inst] = 1'b1;
                data_v[inst]  = words[w];
            end
            hs = valid_v[inst] && ready_o[inst];
            step(inst);
            budget--;
            if (hs) w++;
        end
        valid_v[inst] = 1'b0;
        while (!done_o[inst] && budget > 0) begin
            step(inst);
            budget--;
        end
        check({tag, "_done"}, done_o[inst], 1);
        check({tag, "_busy_at_done"}, busy_o[inst], 0);
        check({tag, "_bit_count"}, bc_o[inst], len);
        check({tag, "_ready_at_done"}, ready_o[inst], 0);
        step(inst);
        step(inst);
        check({tag, "_mismatch"}, mm_o[inst], exp_mm);
        check({tag, "_chain"}, chain_m[inst], exp_chain);
        check({tag, "_shifts"}, shift_cnt[inst] - sc0, len);
        check({tag, "_accepts"}, accept_cnt[inst] - ac0, nw);
        check({tag, "_first_shift_cycle"}, first_sen, 2);
        check({tag, "_first_head"}, first_head, exp_chain[0]);
        check({tag, "_done_held"}, done_o[inst], 1);
        if (stall_after >= 0 && stall_after < nw && stall_len > 1)
            check({tag, "_stall_shifts"}, stall_sen, 0);
    endtask

    // Keep instance 0 fed until bit_count reaches target.
    task automatic feed_until(input logic [WW-1:0] words [8], input int target);
        int budget;
        bit hs;
        budget = 500;
        while (int'(bc_o[0]) != target && budget > 0) begin
            valid_v[0] = 1'b1;
            data_v[0]  = words[feed_w];
            hs = ready_o[0];
            tick();
            if (hs) feed_w++;
            budget--;
        end
    endtask

    logic [WW-1:0] seq [8];
    logic [WW-1:0] rnd [8];

    initial begin
        p_reset  = 1'b1;
        start_v  = '0;
        verify_v = '0;
        valid_v  = '0;
        for (int i = 0; i < int'(N_INST); i++) data_v[i] = '0;
        for (int i = 0; i < 8; i++) seq[i] = WW'(i + 1);
        tick(); tick(); tick();
        for (int i = 0; i < int'(N_INST); i++) begin
            check("rst_ready", ready_o[i], 0);
            check("rst_head", head_o[i], 0);
            check("rst_shift_en", sen_o[i], 0);
            check("rst_busy", busy_o[i], 0);
            check("rst_done", done_o[i], 0);
            check("rst_mismatch", mm_o[i], 0);
            check("rst_bit_count", bc_o[i], 0);
        end
        p_reset = 1'b0;
        tick();

        // Basic stream, then verify against it, then verify with a corrupted word.
        run_pass(0, seq, 1'b0, -1, 0, "t1");
        check("t1_chain_bit0", chain_m[0][0], 1);
        check("t1_chain_bit8", chain_m[0][8], 0);
        run_pass(0, seq, 1'b1, -1, 0, "t2_clean");
        rnd = seq;
        rnd[3] = rnd[3] ^ WW'(8'h10);
        run_pass(0, rnd, 1'b1, -1, 0, "t2_flip");

        // Short chain drops the surplus upper bits of the last word.
        for (int i = 0; i < 8; i++) rnd[i] = 8'hFF;
        run_pass(1, rnd, 1'b0, -1, 0, "t3");

        // Source stall after the second word.
        run_pass(0, seq, 1'b0, 2, 7, "t4");

        // Start during a pass is ignored; reset mid-pass wins over start.
        for (int i = 0; i < 8; i++) rnd[i] = WW'($urandom);
        start_v[0] = 1'b1; verify_v[0] = 1'b0; valid_v[0] = 1'b1; data_v[0] = rnd[0];
        feed_w = 0;
        tick();
        start_v[0] = 1'b0;
        feed_until(rnd, 5);
        check("t5_reach_bc5", bc_o[0], 5);
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        check("t5_start_ignored_bc", bc_o[0], 6);
        check("t5_start_ignored_busy", busy_o[0], 1);
        feed_until(rnd, 20);
        check("t5_reach_bc20", bc_o[0], 20);
        p_reset = 1'b1; start_v[0] = 1'b1;
        tick();
        p_reset = 1'b0; start_v[0] = 1'b0; valid_v[0] = 1'b0;
        check("t5_rst_ready", ready_o[0], 0);
        check("t5_rst_head", head_o[0], 0);
        check("t5_rst_shift_en", sen_o[0], 0);
        check("t5_rst_busy", busy_o[0], 0);
        check("t5_rst_done", done_o[0], 0);
        check("t5_rst_mismatch", mm_o[0], 0);
        check("t5_rst_bit_count", bc_o[0], 0);
        tick();
        check("t5_idle_after_rst", busy_o[0], 0);
        run_pass(0, rnd, 1'b0, -1, 0, "t5_recover");

        // Single-flop chain, then verify against a different bit.
        rnd[0] = 8'h01;
        run_pass(2, rnd, 1'b0, -1, 0, "t6");
        check("t6_chain", chain_m[2][0], 1);
        rnd[0] = 8'hFE;
        run_pass(2, rnd, 1'b1, -1, 0, "t6_verify");

        // Randomized passes on the two wider chains.
        for (int r = 0; r < 10; r++) begin
            int inst, nw, sa;
            inst = r % 2;
            nw   = int'((len_of(inst) + WW - 1) / WW);
            for (int i = 0; i < 8; i++) rnd[i] = WW'($urandom);
            sa = (nw > 1 && ($urandom % 2) == 1) ? int'($urandom_range(1, nw - 1)) : -1;
            run_pass(inst, rnd, 1'($urandom % 2), sa, int'($urandom_range(2, 6)), "rnd");
            if (r % 3 == 0) run_pass(inst, rnd, 1'b1, -1, 0, "rnd_reverify");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
